// File: rtl/lc3_pipe_controller_if.sv
// lc3_pipe_controller_if
//   Bundles the sequencer's pipeline-facing signals.
//   master : the controller (consumes IR/IR_Exec/psr/completion flags, drives enables).
//   slave  : the datapath side.
//   Inputs to controller : complete_instr, complete_data, IR[15:0], IR_Exec[15:0], psr[2:0]
//   Outputs of controller: enable_updatePC, enable_fetch, enable_decode, enable_execute,
//                          enable_writeback, br_taken, bypass_alu_1, bypass_alu_2,
//                          mem_state[1:0], and stall_count[15:0] when LC3_CTRL_PERF_EN is defined.
interface lc3_pipe_controller_if;
    logic        complete_instr;
    logic        complete_data;
    logic [15:0] IR;
    logic [15:0] IR_Exec;
    logic [2:0]  psr;
    logic        enable_updatePC;
    logic        enable_fetch;
    logic        enable_decode;
    logic        enable_execute;
    logic        enable_writeback;
    logic        br_taken;
    logic        bypass_alu_1;
    logic        bypass_alu_2;
    logic [1:0]  mem_state;
`ifdef LC3_CTRL_PERF_EN
    logic [15:0] stall_count;
`endif

    modport master (
`ifdef LC3_CTRL_PERF_EN
        output stall_count,
`endif
        input  complete_instr, complete_data, IR, IR_Exec, psr,
        output enable_updatePC, enable_fetch, enable_decode, enable_execute,
        output enable_writeback, br_taken, bypass_alu_1, bypass_alu_2, mem_state
    );

    modport slave (
`ifdef LC3_CTRL_PERF_EN
        input  stall_count,
`endif
        output complete_instr, complete_data, IR, IR_Exec, psr,
        input  enable_updatePC, enable_fetch, enable_decode, enable_execute,
        input  enable_writeback, br_taken, bypass_alu_1, bypass_alu_2, mem_state
    );
endinterface

// File: rtl/lc3_pipe_controller.sv
// lc3_pipe_controller
//   Central sequencer for the LC-3 5-stage pipeline. Produces per-stage enables, branch-taken,
//   ALU bypass selects and the memory-access state from the decode/execute IRs, PSR and the
//   memory completion flags.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus          : lc3_pipe_controller_if.master (see interface file for signal list)
//   Parameter BR_BUBBLES (2..7): cycles fetch/decode stay frozen after a BR/JMP is decoded.
//   Optional macro LC3_CTRL_PERF_EN: adds bus.stall_count, a saturating count of cycles with a
//   filled pipe and fetch disabled.
module lc3_pipe_controller #(
    parameter int unsigned BR_BUBBLES = 3
) (
    input logic                  clock,
    input logic                  reset,
    lc3_pipe_controller_if.master bus
);
    localparam logic [3:0] OpBr  = 4'b0000;
    localparam logic [3:0] OpAdd = 4'b0001;
    localparam logic [3:0] OpLd  = 4'b0010;
    localparam logic [3:0] OpSt  = 4'b0011;
    localparam logic [3:0] OpAnd = 4'b0101;
    localparam logic [3:0] OpLdr = 4'b0110;
    localparam logic [3:0] OpStr = 4'b0111;
    localparam logic [3:0] OpNot = 4'b1001;
    localparam logic [3:0] OpLdi = 4'b1010;
    localparam logic [3:0] OpSti = 4'b1011;
    localparam logic [3:0] OpJmp = 4'b1100;

    typedef enum logic [1:0] {
        MemRead     = 2'd0,
        MemIndirect = 2'd1,
        MemWrite    = 2'd2,
        MemIdle     = 2'd3
    } mem_state_e;

    mem_state_e mem_q, mem_d;
    logic [1:0] fill_q, fill_d;
    logic [2:0] br_q, br_d;

    logic [3:0] op_dec, op_exe;
    logic       exe_is_alu, dec_is_br;
    logic       mem_stall;
    logic       upc_en, fetch_en, decode_en, execute_en, wb_en, br_taken;

    assign op_dec     = bus.IR[15:12];
    assign op_exe     = bus.IR_Exec[15:12];
    assign exe_is_alu = (op_exe == OpAdd) || (op_exe == OpAnd) || (op_exe == OpNot);
    assign dec_is_br  = (op_dec == OpBr) || (op_dec == OpJmp);
    assign mem_stall  = (mem_q != MemIdle);

    // Stage enables, priority: reset > memory stall > branch bubble > fetch stall > fill.
    always_comb begin
        upc_en     = 1'b0;
        fetch_en   = 1'b0;
        decode_en  = 1'b0;
        execute_en = 1'b0;
        wb_en      = 1'b0;
        br_taken   = 1'b0;
        if (reset) begin
            upc_en = 1'b0;
        end else if (mem_stall) begin
            // Only a completing plain/indirect read retires to the register file.
            wb_en = (mem_q == MemRead) && bus.complete_data;
        end else begin
            execute_en = (fill_q >= 2'd2);
            wb_en      = (fill_q == 2'd3);
            if (br_q != 3'd0) begin
                if (br_q == 3'd1) begin
                    upc_en   = 1'b1;
                    br_taken = (op_exe == OpJmp) ||
                               ((op_exe == OpBr) && |(bus.IR_Exec[11:9] & bus.psr));
                end
            end else if (bus.complete_instr) begin
                upc_en    = 1'b1;
                fetch_en  = 1'b1;
                decode_en = (fill_q >= 2'd1);
            end
        end
    end

    // Memory access FSM.
    always_comb begin
        mem_d = mem_q;
        unique case (mem_q)
            MemIdle: begin
                if (execute_en) begin
                    case (op_exe)
                        OpLd, OpLdr:  mem_d = MemRead;
                        OpLdi, OpSti: mem_d = MemIndirect;
                        OpSt, OpStr:  mem_d = MemWrite;
                        default:      mem_d = MemIdle;
                    endcase
                end
            end
            MemRead:     if (bus.complete_data) mem_d = MemIdle;
            MemIndirect: if (bus.complete_data) mem_d = (op_exe == OpSti) ? MemWrite : MemRead;
            MemWrite:    if (bus.complete_data) mem_d = MemIdle;
        endcase
    end

    // Branch bubble counter and pipeline fill counter.
    always_comb begin
        br_d   = br_q;
        fill_d = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
        if (!mem_stall) begin
            if (br_q != 3'd0) begin
                br_d = br_q - 3'd1;
            end else if (decode_en && dec_is_br && (mem_d == MemIdle)) begin
                // A branch decoded as a memory op starts is re-decoded after the stall.
                br_d = 3'(BR_BUBBLES);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_q  <= MemIdle;
            fill_q <= 2'd0;
            br_q   <= 3'd0;
        end else begin
            mem_q  <= mem_d;
            fill_q <= fill_d;
            br_q   <= br_d;
        end
    end

    assign bus.enable_updatePC  = upc_en;
    assign bus.enable_fetch     = fetch_en;
    assign bus.enable_decode    = decode_en;
    assign bus.enable_execute   = execute_en;
    assign bus.enable_writeback = wb_en;
    assign bus.br_taken         = br_taken;
    assign bus.mem_state        = mem_q;

    // Forward from an ALU-class instruction in execute to its consumer in decode.
    assign bus.bypass_alu_1 = !reset && exe_is_alu &&
        ((op_dec == OpAdd) || (op_dec == OpAnd) || (op_dec == OpNot) ||
         (op_dec == OpLdr) || (op_dec == OpStr) || (op_dec == OpJmp)) &&
        (bus.IR_Exec[11:9] == bus.IR[8:6]);
    assign bus.bypass_alu_2 = !reset && exe_is_alu &&
        ((op_dec == OpAdd) || (op_dec == OpAnd)) && !bus.IR[5] &&
        (bus.IR_Exec[11:9] == bus.IR[2:0]);

`ifdef LC3_CTRL_PERF_EN
    logic [15:0] stall_q;
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= 16'd0;
        end else if ((fill_q == 2'd3) && !fetch_en && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end
    assign bus.stall_count = stall_q;
`endif

    logic unused_ir_bits;
    assign unused_ir_bits = ^{bus.IR[11:9], bus.IR[4:3], bus.IR_Exec[8:0]};
endmodule

// File: tb/tb_lc3_pipe_controller.sv
// tb_lc3_pipe_controller
//   Directed stimulus with hand-computed expected enable vectors pushed to a scoreboard queue;
//   a separate monitor pops one entry per checked cycle on the falling edge and compares.
//   Expected vector bit order: {updatePC, fetch, decode, execute, writeback, br_taken, byp1, byp2}.
module tb_lc3_pipe_controller;
    logic clock = 1'b0;
    logic reset;

    lc3_pipe_controller_if bus ();

    lc3_pipe_controller #(.BR_BUBBLES(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    localparam logic [7:0] EnNone  = 8'b00000_000;
    localparam logic [7:0] EnF1    = 8'b11000_000;
    localparam logic [7:0] EnF2    = 8'b11100_000;
    localparam logic [7:0] EnF3    = 8'b11110_000;
    localparam logic [7:0] EnAll   = 8'b11111_000;
    localparam logic [7:0] EnWb    = 8'b00001_000;
    localparam logic [7:0] EnBack  = 8'b00011_000;
    localparam logic [7:0] EnLastT = 8'b10011_100;
    localparam logic [7:0] EnLastN = 8'b10011_000;
    localparam logic [15:0] Nop    = 16'h1000;
    localparam logic [15:0] Lea    = 16'hE000;

    typedef struct {
        string       name;
        logic [7:0]  en;
        logic [1:0]  ms;
        bit          chk_sc;
        logic [15:0] sc;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] en, input logic [1:0] ms,
                       input bit chk_sc = 1'b0, input logic [15:0] sc = 16'd0);
        exp_t e;
        e.name   = nm;
        e.en     = en;
        e.ms     = ms;
        e.chk_sc = chk_sc;
        e.sc     = sc;
        sb.push_back(e);
    endtask

    // Monitor: compares the DUT outputs against the oldest pending expectation.
    initial begin
        exp_t       e;
        logic [7:0] act;
        bit         bad;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {bus.enable_updatePC, bus.enable_fetch, bus.enable_decode,
                       bus.enable_execute, bus.enable_writeback, bus.br_taken,
                       bus.bypass_alu_1, bus.bypass_alu_2};
                n_vec++;
                bad = (act !== e.en) || (bus.mem_state !== e.ms);
`ifdef LC3_CTRL_PERF_EN
                if (e.chk_sc && (bus.stall_count !== e.sc)) bad = 1'b1;
                if (bad) $display("FAIL %s: got en=%b ms=%0d sc=%0d, want en=%b ms=%0d sc=%0d",
                                  e.name, act, bus.mem_state, bus.stall_count,
                                  e.en, e.ms, e.sc);
`else
                if (bad) $display("FAIL %s: got en=%b ms=%0d, want en=%b ms=%0d",
                                  e.name, act, bus.mem_state, e.en, e.ms);
`endif
                if (bad) n_miss++;
            end
        end
    end

    task automatic branch_seq(input string nm, input logic [15:0] exe_ir, input logic taken);
        bus.IR = 16'h0E05;
        chk({nm, "_dec"}, EnAll, 2'd3);
        tick(); bus.IR = Nop; bus.IR_Exec = exe_ir;
        chk({nm, "_b3"}, EnBack, 2'd3);
        tick(); chk({nm, "_b2"}, EnBack, 2'd3);
        tick(); chk({nm, "_b1"}, taken ? EnLastT : EnLastN, 2'd3);
        tick(); bus.IR_Exec = Lea;
        chk({nm, "_done"}, EnAll, 2'd3);
        tick();
    endtask

    initial begin
        reset              = 1'b1;
        bus.complete_instr = 1'b1;
        bus.complete_data  = 1'b0;
        bus.IR             = Nop;
        bus.IR_Exec        = Lea;
        bus.psr            = 3'b010;

        // Reset and fill.
        tick(); chk("reset", EnNone, 2'd3);
        tick(); reset = 1'b0; chk("fill1", EnF1, 2'd3, 1'b1, 16'd0);
        tick(); chk("fill2", EnF2, 2'd3);
        tick(); chk("fill3", EnF3, 2'd3);
        tick(); chk("fill4", EnAll, 2'd3, 1'b1, 16'd0);

        // LDR: read state held for three cycles, writeback only on completion.
        tick(); bus.IR_Exec = 16'h6000; chk("ldr_issue", EnAll, 2'd3);
        tick(); chk("ldr_wait1", EnNone, 2'd0);
        tick(); chk("ldr_wait2", EnNone, 2'd0);
        tick(); bus.complete_data = 1'b1; chk("ldr_done", EnWb, 2'd0);
        tick(); bus.complete_data = 1'b0; bus.IR_Exec = Lea; chk("ldr_idle", EnAll, 2'd3);

        // STI: 3 -> 1 -> 2 -> 3, no writeback.
        tick(); bus.IR_Exec = 16'hB000; chk("sti_issue", EnAll, 2'd3);
        tick(); chk("sti_ind", EnNone, 2'd1);
        tick(); bus.complete_data = 1'b1; chk("sti_ind_done", EnNone, 2'd1);
        tick(); bus.complete_data = 1'b0; chk("sti_write", EnNone, 2'd2);
        tick(); bus.complete_data = 1'b1; chk("sti_write_done", EnNone, 2'd2);
        tick(); bus.complete_data = 1'b0; bus.IR_Exec = Lea; chk("sti_idle", EnAll, 2'd3);

        // LDI: 3 -> 1 -> 0 -> 3, writeback on final read.
        tick(); bus.IR_Exec = 16'hA000; chk("ldi_issue", EnAll, 2'd3);
        tick(); bus.complete_data = 1'b1; chk("ldi_ind", EnNone, 2'd1);
        tick(); chk("ldi_read", EnWb, 2'd0);
        tick(); bus.complete_data = 1'b0; bus.IR_Exec = Lea; chk("ldi_idle", EnAll, 2'd3);

        // Branch bubbles: taken BR, not-taken BR, JMP.
        tick();
        branch_seq("br_taken", 16'h0E05, 1'b1);
        branch_seq("br_ntaken", 16'h0805, 1'b0);
        branch_seq("jmp", 16'hC1C0, 1'b1);

        // BR decoded while a load leaves idle: br_cnt loads only after the stall.
        bus.IR = 16'h0E05; bus.IR_Exec = 16'h6000; chk("sim_issue", EnAll, 2'd3);
        tick(); chk("sim_wait", EnNone, 2'd0);
        tick(); bus.complete_data = 1'b1; chk("sim_done", EnWb, 2'd0);
        tick(); bus.complete_data = 1'b0; bus.IR_Exec = Lea; chk("sim_brdec", EnAll, 2'd3);
        tick(); bus.IR = Nop; chk("sim_b3", EnBack, 2'd3);
        tick(); chk("sim_b2", EnBack, 2'd3);
        tick(); chk("sim_b1", EnLastN, 2'd3);
        tick(); chk("sim_after", EnAll, 2'd3);

        // Bypass selects.
        tick(); bus.IR_Exec = 16'h1601; bus.IR = 16'h12C3; chk("byp_both", 8'b11111_011, 2'd3);
        tick(); bus.IR = 16'h12E3; chk("byp_imm", 8'b11111_010, 2'd3);
        tick(); bus.IR = 16'h66C0; chk("byp_ldr", 8'b11111_010, 2'd3);
        tick(); bus.IR_Exec = Lea; bus.IR = 16'h12C3; chk("byp_noalu", EnAll, 2'd3);
        tick(); bus.IR = Nop;

        // Fetch stall leaves execute/writeback running.
        bus.complete_instr = 1'b0; chk("fstall", EnBack, 2'd3);
        tick(); bus.complete_instr = 1'b1; chk("fstall_end", EnAll, 2'd3);

        // Refill from reset, then ten fetch-stall cycles for the stall counter.
        tick(); reset = 1'b1; chk("reset2", EnNone, 2'd3);
        tick(); reset = 1'b0; chk("refill1", EnF1, 2'd3, 1'b1, 16'd0);
        tick(); chk("refill2", EnF2, 2'd3, 1'b1, 16'd0);
        tick(); chk("refill3", EnF3, 2'd3, 1'b1, 16'd0);
        tick(); chk("refill4", EnAll, 2'd3, 1'b1, 16'd0);
        for (int k = 0; k < 10; k++) begin
            tick(); bus.complete_instr = 1'b0;
            chk($sformatf("pstall%0d", k), EnBack, 2'd3, 1'b1, 16'(k));
        end
        tick(); bus.complete_instr = 1'b1; chk("pstall_end", EnAll, 2'd3, 1'b1, 16'd10);

        // Reset in the middle of an LDI.
        tick(); bus.IR_Exec = 16'hA000; chk("ldi2_issue", EnAll, 2'd3, 1'b1, 16'd10);
        tick(); chk("ldi2_ind", EnNone, 2'd1, 1'b1, 16'd10);
        tick(); reset = 1'b1;
        tick(); reset = 1'b0; bus.IR_Exec = Lea; chk("post_reset1", EnF1, 2'd3, 1'b1, 16'd0);
        tick(); chk("post_reset2", EnF2, 2'd3, 1'b1, 16'd0);

        tick(); tick();
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
